// File: rtl/cnn_sequencer.sv
// cnn_sequencer: fills five memory regions from host byte writes, then steps four CNN layers.
// Optional per-layer watchdog (ERROR state, timeout flag) enabled by defining CNN_SEQ_TIMEOUT_EN.
module cnn_sequencer #(
   parameter int ADDR_W         = 19,
   parameter int SIZE0          = 10000,
   parameter int SIZE1          = 400,
   parameter int SIZE2          = 12800,
   parameter int SIZE3          = 230400,
   parameter int SIZE4          = 10600,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              host_write,
   input  logic [2:0]        host_region,
   input  logic [7:0]        host_data,
   input  logic              rerun,
   output logic [4:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic [3:0]        layer_start,
   input  logic [3:0]        layer_done,
   output logic              all_loaded,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              host_err,
   output logic              timeout
);
   // state   | meaning
   // S_LOAD  | accepting host bytes until every region is full
   // S_START | one-cycle layer_start pulse for layer lidx
   // S_WAIT  | waiting for layer_done[lidx]
   // S_DONE  | all four layers finished; rerun reloads the input image
   // S_ERROR | watchdog expired (timeout build only); left by reset alone

   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_LOAD, S_START, S_WAIT, S_DONE
`ifdef CNN_SEQ_TIMEOUT_EN
      , S_ERROR
`endif
   } state_t;

   state_t                   state_q, state_d;
   logic [1:0]               lidx_q, lidx_d;
   logic [4:0][CNT_W-1:0]    cnt_q, cnt_d;
   logic [4:0]               mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
   logic [7:0]               mem_wdata_q, mem_wdata_d;
   logic [3:0]               layer_start_q, layer_start_d;
   logic                     all_loaded_q, all_loaded_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     overflow_q, overflow_d;
   logic                     host_err_q, host_err_d;
   logic                     timeout_q, timeout_d;

`ifdef CNN_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0]          wait_cnt_q, wait_cnt_d;

   // Zero outside WAIT, so every entry into WAIT starts a fresh count.
   assign wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 1'b1 : '0;
`endif

   function automatic logic [CNT_W-1:0] region_size(input int r);
      case (r)
         0:       region_size = CNT_W'(SIZE0);
         1:       region_size = CNT_W'(SIZE1);
         2:       region_size = CNT_W'(SIZE2);
         3:       region_size = CNT_W'(SIZE3);
         default: region_size = CNT_W'(SIZE4);
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_LOAD;
         lidx_q        <= '0;
         cnt_q         <= '0;
         mem_we_q      <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         layer_start_q <= '0;
         all_loaded_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         overflow_q    <= 1'b0;
         host_err_q    <= 1'b0;
         timeout_q     <= 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
         wait_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         lidx_q        <= lidx_d;
         cnt_q         <= cnt_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         layer_start_q <= layer_start_d;
         all_loaded_q  <= all_loaded_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         overflow_q    <= overflow_d;
         host_err_q    <= host_err_d;
         timeout_q     <= timeout_d;
`ifdef CNN_SEQ_TIMEOUT_EN
         wait_cnt_q    <= wait_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      lidx_d  = lidx_q;
      case (state_q)
         S_LOAD: begin
            if (all_loaded_q) begin
               state_d = S_START;
               lidx_d  = 2'd0;
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (layer_done[lidx_q]) begin
               if (lidx_q == 2'd3) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_START;
                  lidx_d  = lidx_q + 2'd1;
               end
            end
`ifdef CNN_SEQ_TIMEOUT_EN
            else if (wait_cnt_q == TO_LAST) begin
               state_d = S_ERROR;
            end
`endif
         end
         S_DONE: begin
            if (rerun) state_d = S_LOAD;
         end
`ifdef CNN_SEQ_TIMEOUT_EN
         S_ERROR: state_d = S_ERROR;
`endif
         default: state_d = S_LOAD;
      endcase
   end

   // Outputs are derived from the next state so each flop lines up with the state it describes.
   always_comb begin
      cnt_d       = cnt_q;
      mem_we_d    = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      overflow_d  = overflow_q;
      host_err_d  = host_err_q;
      if (host_write) begin
         if (state_q != S_LOAD) begin
            host_err_d = 1'b1;
         end else begin
            for (int r = 0; r < 5; r++) begin
               if (host_region == 3'(r)) begin
                  if (cnt_q[r] == region_size(r)) begin
                     overflow_d = 1'b1;
                  end else begin
                     mem_we_d[r] = 1'b1;
                     mem_addr_d  = cnt_q[r][ADDR_W-1:0];
                     mem_wdata_d = host_data;
                     cnt_d[r]    = cnt_q[r] + 1'b1;
                  end
               end
            end
         end
      end
      if (state_q == S_DONE && rerun) cnt_d[0] = '0;

      all_loaded_d = 1'b1;
      for (int r = 0; r < 5; r++) begin
         if (cnt_d[r] != region_size(r)) all_loaded_d = 1'b0;
      end

      layer_start_d = '0;
      if (state_d == S_START) layer_start_d[lidx_d] = 1'b1;
      busy_d = (state_d == S_START) || (state_d == S_WAIT);
      done_d = (state_d == S_DONE);
`ifdef CNN_SEQ_TIMEOUT_EN
      timeout_d = (state_d == S_ERROR);
`else
      timeout_d = 1'b0;
`endif
   end

   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign layer_start = layer_start_q;
   assign all_loaded  = all_loaded_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign overflow    = overflow_q;
   assign host_err    = host_err_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_cnn_sequencer.sv
// Scoreboard bench for cnn_sequencer with small regions (4,2,2,2,2) and a 20-cycle watchdog.
// Stimulus pushes expected memory writes and layer starts; a negedge monitor pops and compares.
module tb_cnn_sequencer;
   localparam int AW = 19;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          host_write = 1'b0;
   logic [2:0]    host_region = '0;
   logic [7:0]    host_data = '0;
   logic          rerun = 1'b0;
   logic [4:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [3:0]    layer_start;
   logic [3:0]    layer_done;
   logic [3:0]    resp_done = '0;
   logic [3:0]    man_done = '0;
   logic          all_loaded, busy, done, overflow, host_err, timeout;

   assign layer_done = resp_done | man_done;

   cnn_sequencer #(
      .ADDR_W(AW), .SIZE0(4), .SIZE1(2), .SIZE2(2), .SIZE3(2), .SIZE4(2),
      .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk), .reset(reset),
      .host_write(host_write), .host_region(host_region), .host_data(host_data),
      .rerun(rerun),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .layer_start(layer_start), .layer_done(layer_done),
      .all_loaded(all_loaded), .busy(busy), .done(done),
      .overflow(overflow), .host_err(host_err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct { int region; int addr; int data; int cyc; } wr_t;
   typedef struct { int layer; int cyc; } ls_t;

   wr_t        exp_wr[$];
   ls_t        exp_ls[$];
   int         sizes[5] = '{4, 2, 2, 2, 2};
   int         m_cnt[5];
   bit         m_ovf, m_err, m_load;
   int         plan_layers = 4;
   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         ls_seen = 0;
   bit         mon_en = 1'b0;
   bit         resp_en = 1'b0;
   wr_t        mon_w;
   ls_t        mon_l;
   logic [3:0] ls_hold;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic bit all_full();
      for (int r = 0; r < 5; r++) if (m_cnt[r] != sizes[r]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_reset();
      for (int r = 0; r < 5; r++) m_cnt[r] = 0;
      m_ovf = 1'b0;
      m_err = 1'b0;
      m_load = 1'b1;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_we != 5'b0) begin
            if (exp_wr.size() == 0) begin
               chk("unexpected_mem_we", 64'(mem_we), 64'(0));
            end else begin
               mon_w = exp_wr.pop_front();
               chk("mem_we", 64'(mem_we), 64'(1) << mon_w.region);
               chk("mem_addr", 64'(mem_addr), 64'(mon_w.addr));
               chk("mem_wdata", 64'(mem_wdata), 64'(mon_w.data));
               chk("mem_we_cycle", 64'(cyc), 64'(mon_w.cyc));
            end
         end
         if (layer_start != 4'b0) begin
            ls_seen++;
            if (exp_ls.size() == 0) begin
               chk("unexpected_layer_start", 64'(layer_start), 64'(0));
            end else begin
               mon_l = exp_ls.pop_front();
               chk("layer_start", 64'(layer_start), 64'(1) << mon_l.layer);
               if (mon_l.cyc >= 0) chk("layer_start_cycle", 64'(cyc), 64'(mon_l.cyc));
               chk("busy_at_start", 64'(busy), 64'(1));
            end
            chk("start_we_exclusive", 64'(mem_we), 64'(0));
         end
      end
   end

   // Answers each layer_start with the matching layer_done three cycles later.
   initial forever begin
      @(negedge clk);
      if (resp_en && layer_start != 4'b0) begin
         ls_hold = layer_start;
         repeat (3) @(posedge clk);
         #1 resp_done = ls_hold;
         @(posedge clk);
         #1 resp_done = 4'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_idle(input string pfx);
      chk({pfx, "_mem_we"}, 64'(mem_we), 64'(0));
      chk({pfx, "_mem_addr"}, 64'(mem_addr), 64'(0));
      chk({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
      chk({pfx, "_layer_start"}, 64'(layer_start), 64'(0));
      chk({pfx, "_all_loaded"}, 64'(all_loaded), 64'(0));
      chk({pfx, "_busy"}, 64'(busy), 64'(0));
      chk({pfx, "_done"}, 64'(done), 64'(0));
      chk({pfx, "_overflow"}, 64'(overflow), 64'(0));
      chk({pfx, "_host_err"}, 64'(host_err), 64'(0));
      chk({pfx, "_timeout"}, 64'(timeout), 64'(0));
   endtask

   task automatic hwr(input int r, input int d);
      host_write = 1'b1;
      host_region = 3'(r);
      host_data = 8'(d);
      if (!m_load) begin
         m_err = 1'b1;
      end else if (r < 5) begin
         if (m_cnt[r] < sizes[r]) begin
            exp_wr.push_back('{region: r, addr: m_cnt[r], data: d, cyc: cyc + 1});
            m_cnt[r]++;
            if (all_full()) begin
               m_load = 1'b0;
               for (int l = 0; l < plan_layers; l++)
                  exp_ls.push_back('{layer: l, cyc: (l == 0) ? cyc + 2 : -1});
            end
         end else begin
            m_ovf = 1'b1;
         end
      end
      tick(1);
      host_write = 1'b0;
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("host_err", 64'(host_err), 64'(m_err));
      chk("all_loaded", 64'(all_loaded), 64'(all_full()));
   endtask

   // Fills every region that still has room, in random order, with junk-region writes mixed in.
   task automatic load_random(input bit junk);
      int lst[$];
      int j, t;
      for (int r = 0; r < 5; r++)
         for (int k = m_cnt[r]; k < sizes[r]; k++) lst.push_back(r);
      if (junk) repeat (3) lst.push_back(5 + $urandom_range(0, 2));
      for (int i = lst.size() - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = lst[i];
         lst[i] = lst[j];
         lst[j] = t;
      end
      while (lst[lst.size() - 1] >= 5) void'(lst.pop_back());
      foreach (lst[i]) begin
         tick($urandom_range(0, 2));
         hwr(lst[i], $urandom_range(0, 255));
      end
   endtask

   task automatic wait_ls(input logic [3:0] want, input int budget);
      int i = 0;
      while (layer_start != want && i < budget) begin
         tick(1);
         i++;
      end
      chk("wait_layer_start", 64'(layer_start), 64'(want));
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      while (!done && i < budget) begin
         tick(1);
         i++;
      end
      chk("wait_done", 64'(done), 64'(1));
   endtask

   task automatic do_reset(input string pfx);
      reset = 1'b1;
      host_write = 1'b0;
      rerun = 1'b0;
      man_done = 4'b0;
      tick(2);
      chk_idle(pfx);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      do_reset("reset");
      mon_en = 1'b1;

      // Region 0 back-to-back: addresses 0..3, data A0..A3.
      for (int i = 0; i < 4; i++) hwr(0, 8'hA0 + i);
      tick(2);
      chk("wr_queue_drained_a", 64'(exp_wr.size()), 64'(0));

      // rerun outside DONE must not disturb the region 0 count.
      rerun = 1'b1;
      tick(1);
      rerun = 1'b0;

      // Overflow on region 1, junk region ignored.
      hwr(1, $urandom_range(0, 255));
      hwr(1, $urandom_range(0, 255));
      hwr(1, $urandom_range(0, 255));
      hwr(6, $urandom_range(0, 255));
      tick(2);
      chk("overflow_sticky", 64'(overflow), 64'(1));
      chk("wr_queue_drained_b", 64'(exp_wr.size()), 64'(0));

      // Finish the load and run all four layers.
      plan_layers = 4;
      ls_seen = 0;
      resp_en = 1'b1;
      load_random(1'b1);
      wait_done(200);
      resp_en = 1'b0;
      chk("busy_in_done", 64'(busy), 64'(0));
      chk("layers_seen", 64'(ls_seen), 64'(4));
      chk("ls_queue_drained", 64'(exp_ls.size()), 64'(0));

      // Host write outside LOAD.
      hwr(2, $urandom_range(0, 255));
      tick(2);
      chk("done_holds", 64'(done), 64'(1));

      // Rerun: reload the image only, then stop in WAIT of layer 1.
      rerun = 1'b1;
      tick(1);
      rerun = 1'b0;
      m_cnt[0] = 0;
      m_load = 1'b1;
      chk("rerun_done", 64'(done), 64'(0));
      chk("rerun_all_loaded", 64'(all_loaded), 64'(0));
      chk("rerun_busy", 64'(busy), 64'(0));
      plan_layers = 2;
      for (int i = 0; i < 4; i++) hwr(0, $urandom_range(0, 255));
      wait_ls(4'b0001, 10);
      tick(3);
      man_done = 4'b0001;
      tick(1);
      man_done = 4'b0000;
      wait_ls(4'b0010, 10);
      man_done = 4'b0001;
      repeat (6) begin
         tick(1);
         chk("wrong_done_busy", 64'(busy), 64'(1));
         chk("wrong_done_done", 64'(done), 64'(0));
      end
      reset = 1'b1;
      tick(1);
      chk_idle("midwait_reset");
      man_done = 4'b0000;
      tick(1);
      reset = 1'b0;
      chk("ls_queue_drained_c", 64'(exp_ls.size()), 64'(0));
      chk("wr_queue_drained_c", 64'(exp_wr.size()), 64'(0));
      model_reset();
      tick(4);

      // Fresh full load, then leave layer 0 unanswered.
`ifdef CNN_SEQ_TIMEOUT_EN
      plan_layers = 1;
`else
      plan_layers = 4;
`endif
      load_random(1'b0);
      wait_ls(4'b0001, 10);
`ifdef CNN_SEQ_TIMEOUT_EN
      tick(14);
      chk("timeout_early", 64'(timeout), 64'(0));
      chk("busy_before_timeout", 64'(busy), 64'(1));
      begin
         int i = 0;
         while (!timeout && i < 20) begin
            tick(1);
            i++;
         end
      end
      chk("timeout_set", 64'(timeout), 64'(1));
      chk("busy_in_error", 64'(busy), 64'(0));
      chk("done_in_error", 64'(done), 64'(0));
      man_done = 4'b0001;
      rerun = 1'b1;
      tick(5);
      man_done = 4'b0000;
      rerun = 1'b0;
      chk("error_sticky_timeout", 64'(timeout), 64'(1));
      chk("error_sticky_busy", 64'(busy), 64'(0));
`else
      tick(40);
      chk("no_timeout", 64'(timeout), 64'(0));
      chk("wait_forever_busy", 64'(busy), 64'(1));
      man_done = 4'b0001;
      tick(1);
      man_done = 4'b0000;
      resp_en = 1'b1;
      wait_done(100);
      resp_en = 1'b0;
      chk("busy_final_done", 64'(busy), 64'(0));
`endif
      tick(2);
      chk("ls_queue_drained_d", 64'(exp_ls.size()), 64'(0));
      do_reset("final_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/cnn_sequencer.md
CNN_SEQUENCER -- requirements
Module: cnn_sequencer

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 19, meaning the width of every memory address output.
REQ-002 The module SHALL have parameters SIZE0..SIZE4, defaults 10000, 400, 12800, 230400, 10600, meaning the byte counts of the input, L1, L2, L3 and L4 weight regions.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the per-layer watchdog limit.
REQ-004 The module SHALL have port clk, input, 1 bit, meaning the clock.
REQ-005 The module SHALL have port reset, input, 1 bit, meaning the reset, which is synchronous and active-high.
REQ-006 The module SHALL have ports host_write (input, 1), host_region (input, 3) and host_data (input, 8), meaning a host byte write to a region.
REQ-007 The module SHALL have port rerun, input, 1 bit, meaning a request to reload the input image only and run again.
REQ-008 The module SHALL have ports mem_we (output, 5), mem_addr (output, ADDR_W) and mem_wdata (output, 8), meaning the one-hot region write port.
REQ-009 The module SHALL have ports layer_start (output, 4) and layer_done (input, 4), meaning the one-hot layer handshake.
REQ-010 The module SHALL have ports all_loaded, busy, done, overflow, host_err and timeout, all outputs of 1 bit, meaning status.

Function
REQ-011 The FSM SHALL have the states LOAD, START, WAIT, DONE and ERROR, with an internal layer index lidx in the range 0..3.
REQ-012 In LOAD, each host_write with host_region r<5 and count[r]<SIZEr SHALL, on the next cycle, assert mem_we[r] for exactly one cycle with mem_addr=count[r] and mem_wdata=host_data, and SHALL increment count[r].
REQ-013 A host_write to a full region SHALL produce no mem_we and SHALL set overflow, which is sticky until reset.
REQ-014 A host_write with host_region>=5 SHALL be ignored silently.
REQ-015 A host_write in any state other than LOAD SHALL be ignored and SHALL set host_err, which is sticky until reset.
REQ-016 all_loaded SHALL be high whenever count[r]==SIZEr for every region r.
REQ-017 In LOAD, the cycle after all_loaded rises (including the cycle of the final mem_we), the FSM SHALL enter START with lidx=0.
REQ-018 In START, the module SHALL pulse layer_start[lidx] for one cycle and then enter WAIT.
REQ-019 In WAIT, layer_done[lidx]=1 SHALL advance the FSM to START with lidx+1, or to DONE when lidx==3.
REQ-020 In WAIT, layer_done bits other than bit lidx SHALL be ignored.
REQ-021 busy SHALL be 1 in START and WAIT, and 0 otherwise.
REQ-022 done SHALL be 1 only in DONE.
REQ-023 In DONE, rerun=1 SHALL clear count[0] only, clear all_loaded, and enter LOAD; the weight counts SHALL be retained.
REQ-024 rerun SHALL be ignored outside DONE.
REQ-025 layer_start and mem_we SHALL never be asserted in the same cycle.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On reset, the FSM SHALL enter LOAD, and all counts and lidx SHALL be set to 0.
REQ-028 On reset, mem_we, mem_addr, mem_wdata, layer_start, all_loaded, busy, done, overflow, host_err and timeout SHALL all be 0.
REQ-029 Reset asserted mid-load or mid-layer SHALL abort the operation at the next edge; no layer_start pulse and no mem_we SHALL follow the reset.

Configuration
REQ-030 With CNN_SEQ_TIMEOUT_EN defined, a cycle counter SHALL clear on entry to WAIT.
REQ-031 With CNN_SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES in WAIT without layer_done[lidx] SHALL enter ERROR and set timeout.
REQ-032 ERROR SHALL be left only by reset, and busy SHALL be 0 in ERROR.
REQ-033 Without CNN_SEQ_TIMEOUT_EN, there SHALL be no counter and no ERROR state; timeout SHALL be tied to 0 and WAIT SHALL wait indefinitely.

Verification (bench parameters: SIZE0..4=4,2,2,2,2 and TIMEOUT_CYCLES=20)
REQ-034 Write 4 bytes 0xA0..0xA3 to region 0 -> mem_we=5'b00001 with addresses 0..3 and matching data, each exactly one cycle after its write.
REQ-035 Load all regions, then return layer_done[i] 3 cycles after each layer_start[i] -> layer_start pulses 0001, 0010, 0100, 1000 in order, then done=1 and busy=0.
REQ-036 Write a third byte to region 1 and a byte to region 6 -> overflow=1 with no mem_we for either write.
REQ-037 In DONE, pulse rerun, then write 4 bytes to region 0 -> all_loaded rises and the run restarts at layer 0 without any weight writes.
REQ-038 In WAIT with lidx=1, assert layer_done=4'b0001, then assert reset mid-wait -> the FSM stays in WAIT, then reset returns it to LOAD with all outputs at 0.
REQ-039 With CNN_SEQ_TIMEOUT_EN defined, give no layer_done for 20 cycles after layer_start[0] -> timeout=1, busy=0, and the FSM stays in ERROR until reset.
